// File: rtl/lsu_arb_pkg.sv
// Shared types and constants for the LSU arbiter: FSM states and the
// 16-lane vector word used on both the requester and LSU sides.
package lsu_arb_pkg;

   localparam int LANES  = 16;
   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] lane_vec_t [LANES];

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WRITE = 2'b01,
      READ  = 2'b10,
      RESP  = 2'b11
   } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_picker #(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   grant,
   output logic            any_req
);

   localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

   logic [PW:0] idx;

   // Walk offsets from the farthest down to zero so the closest hit to ptr wins.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= NREQ_W) begin
            idx = idx - NREQ_W;
         end
         if (req[idx[PW-1:0]]) begin
            grant   = idx[PW-1:0];
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one vector LSU among NREQ requesters; runs one
// write or read at a time, acks with a one-cycle pulse, and aborts stalled accesses.
module lsu_arbiter
   import lsu_arb_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NREQ-1:0]              req_i,
   input  logic [NREQ-1:0]              we_i,
   input  logic [NREQ-1:0]              vec_i,
   input  logic [NREQ-1:0][31:0]        addr_i,
   input  logic [NREQ-1:0][WORD_W-1:0]  wdata_i,
   input  lane_vec_t                    wvec_i [NREQ],
   output logic [NREQ-1:0]              ack_o,
   output logic [NREQ-1:0]              err_o,
   output logic [WORD_W-1:0]            rdata_o,
   output lane_vec_t                    rvec_o,
   output logic [31:0]                  address,
   output logic                         memWriteM,
   output logic                         memtoRegW,
   output logic                         memSrcM,
   output logic [WORD_W-1:0]            data_in,
   output lane_vec_t                    data_in_vec,
   input  logic [WORD_W-1:0]            data_out,
   input  lane_vec_t                    data_out_vec,
   input  logic                         write_done,
   input  logic                         data_ready
);

   localparam int          PW       = $clog2(NREQ);
   localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit          WD_EN    = (TIMEOUT > 0);
   localparam logic [CW-1:0] CNT_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;
   localparam logic [PW:0] NREQ_W   = (PW+1)'(NREQ);

   state_t              state_reg, state_next;
   logic [PW-1:0]       pick_idx;
   logic                any_req;
   logic [PW-1:0]       grant_reg, rr_reg, rr_wrap;
   logic [PW:0]         rr_sum;
   logic                vec_reg, abort_reg;
   logic [31:0]         addr_reg;
   logic [WORD_W-1:0]   wdata_reg, rdata_reg;
   lane_vec_t           wvec_reg, rvec_reg;
   logic [CW-1:0]       cnt_reg;
   logic                active, wd_expired;
   logic                load_cmd, capture_rd, timeout_hit;

   rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
      .req     (req_i),
      .ptr     (rr_reg),
      .grant   (pick_idx),
      .any_req (any_req)
   );

   assign active     = (state_reg == WRITE) || (state_reg == READ);
   assign wd_expired = WD_EN && (cnt_reg == CNT_LAST);
   assign rr_sum     = {1'b0, grant_reg} + (PW+1)'(1);
   assign rr_wrap    = (rr_sum == NREQ_W) ? '0 : rr_sum[PW-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A completion in the same cycle as the watchdog expiry takes priority.
   always_comb begin
      state_next  = state_reg;
      load_cmd    = 1'b0;
      capture_rd  = 1'b0;
      timeout_hit = 1'b0;
      case (state_reg)
         IDLE: begin
            if (any_req) begin
               load_cmd   = 1'b1;
               state_next = we_i[pick_idx] ? WRITE : READ;
            end
         end
         WRITE: begin
            if (write_done) begin
               state_next = RESP;
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               state_next  = RESP;
            end
         end
         READ: begin
            if (data_ready) begin
               capture_rd = 1'b1;
               state_next = RESP;
            end else if (wd_expired) begin
               timeout_hit = 1'b1;
               state_next  = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_reg <= '0;
         rr_reg    <= '0;
         vec_reg   <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         cnt_reg   <= '0;
         abort_reg <= 1'b0;
         rdata_reg <= '0;
         for (int l = 0; l < LANES; l++) begin
            wvec_reg[l] <= '0;
            rvec_reg[l] <= '0;
         end
      end else begin
         if (load_cmd) begin
            grant_reg <= pick_idx;
            vec_reg   <= vec_i[pick_idx];
            addr_reg  <= addr_i[pick_idx];
            wdata_reg <= wdata_i[pick_idx];
            wvec_reg  <= wvec_i[pick_idx];
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
         end else if (active) begin
            cnt_reg <= cnt_reg + CW'(1);
         end
         if (timeout_hit) begin
            abort_reg <= 1'b1;
         end
         if (capture_rd) begin
            rdata_reg <= data_out;
            rvec_reg  <= data_out_vec;
         end
         if (state_reg == RESP) begin
            rr_reg <= rr_wrap;
         end
      end
   end

   // LSU-facing outputs are pure decodes of state and latched command.
   assign memWriteM = (state_reg == WRITE);
   assign memtoRegW = (state_reg == READ);
   assign memSrcM   = active & vec_reg;
   assign address   = active ? addr_reg : '0;
   assign data_in   = (state_reg == WRITE) ? wdata_reg : '0;
   assign rdata_o   = rdata_reg;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign data_in_vec[gi] = (state_reg == WRITE) ? wvec_reg[gi] : '0;
         assign rvec_o[gi]      = rvec_reg[gi];
      end
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign ack_o[gi] = (state_reg == RESP) && (grant_reg == PW'(gi));
         assign err_o[gi] = ack_o[gi] & abort_reg;
      end
   endgenerate

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with a transaction-level reference model
// checked on every falling edge, plus literal expectations per scenario.
module tb_lsu_arbiter;
   import lsu_arb_pkg::*;

   localparam int NREQ    = 2;
   localparam int TIMEOUT = 8;
   localparam int P_IDLE = 0, P_WR = 1, P_RD = 2, P_ACK = 3;

   typedef logic [$clog2(NREQ)-1:0] idx_t;

   logic                         clk = 1'b0;
   logic                         reset = 1'b0;
   logic [NREQ-1:0]              req_i = '0;
   logic [NREQ-1:0]              we_i = '0;
   logic [NREQ-1:0]              vec_i = '0;
   logic [NREQ-1:0][31:0]        addr_i = '0;
   logic [NREQ-1:0][WORD_W-1:0]  wdata_i = '0;
   lane_vec_t                    wvec_i [NREQ];
   logic [NREQ-1:0]              ack_o, err_o;
   logic [WORD_W-1:0]            rdata_o;
   lane_vec_t                    rvec_o;
   logic [31:0]                  address;
   logic                         memWriteM, memtoRegW, memSrcM;
   logic [WORD_W-1:0]            data_in;
   lane_vec_t                    data_in_vec;
   logic [WORD_W-1:0]            data_out = '0;
   lane_vec_t                    data_out_vec;
   logic                         write_done = 1'b0;
   logic                         data_ready = 1'b0;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   lsu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_i        (req_i),
      .we_i         (we_i),
      .vec_i        (vec_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .wvec_i       (wvec_i),
      .ack_o        (ack_o),
      .err_o        (err_o),
      .rdata_o      (rdata_o),
      .rvec_o       (rvec_o),
      .address      (address),
      .memWriteM    (memWriteM),
      .memtoRegW    (memtoRegW),
      .memSrcM      (memSrcM),
      .data_in      (data_in),
      .data_in_vec  (data_in_vec),
      .data_out     (data_out),
      .data_out_vec (data_out_vec),
      .write_done   (write_done),
      .data_ready   (data_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [255:0] flat(input lane_vec_t v);
      logic [255:0] f;
      f = '0;
      for (int l = 0; l < LANES; l++) f[l*WORD_W +: WORD_W] = v[l];
      return f;
   endfunction

   // First requester asking at or after start, modulo NREQ; -1 if none.
   function automatic int pick(input logic [NREQ-1:0] r, input int start);
      for (int k = 0; k < NREQ; k++) begin
         if (((r >> ((start + k) % NREQ)) & 1) != 0) return (start + k) % NREQ;
      end
      return -1;
   endfunction

   // Reference model: one outstanding transaction, described by its phase.
   int          m_phase, m_rr, m_own, m_age, m_pick;
   idx_t        m_sel;
   bit          m_err, m_vec;
   logic [31:0] m_addr;
   logic [15:0] m_wdata, m_rdata;
   lane_vec_t   m_wvec, m_rvec;

   always_comb m_pick = pick(req_i, m_rr);
   always_comb m_sel  = idx_t'((m_pick < 0) ? 0 : m_pick);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_phase <= P_IDLE; m_rr <= 0; m_own <= 0; m_age <= 0; m_err <= 1'b0; m_vec <= 1'b0;
         m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
         for (int l = 0; l < LANES; l++) begin
            m_wvec[l] <= '0;
            m_rvec[l] <= '0;
         end
      end else begin
         case (m_phase)
            P_IDLE: if (m_pick >= 0) begin
               m_own <= m_pick; m_vec <= vec_i[m_sel]; m_addr <= addr_i[m_sel];
               m_wdata <= wdata_i[m_sel]; m_wvec <= wvec_i[m_sel];
               m_err <= 1'b0; m_age <= 0;
               m_phase <= we_i[m_sel] ? P_WR : P_RD;
            end
            P_WR: if (write_done) m_phase <= P_ACK;
                  else if (TIMEOUT > 0 && m_age == TIMEOUT - 1) begin m_phase <= P_ACK; m_err <= 1'b1; end
                  else m_age <= m_age + 1;
            P_RD: if (data_ready) begin
                     m_phase <= P_ACK; m_rdata <= data_out; m_rvec <= data_out_vec;
                  end
                  else if (TIMEOUT > 0 && m_age == TIMEOUT - 1) begin m_phase <= P_ACK; m_err <= 1'b1; end
                  else m_age <= m_age + 1;
            default: begin
               m_rr <= (m_own + 1) % NREQ;
               m_phase <= P_IDLE;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("memWriteM", 256'(memWriteM), 256'(m_phase == P_WR));
         chk("memtoRegW", 256'(memtoRegW), 256'(m_phase == P_RD));
         chk("memSrcM", 256'(memSrcM), 256'((m_phase == P_WR || m_phase == P_RD) && m_vec));
         chk("address", 256'(address), 256'((m_phase == P_WR || m_phase == P_RD) ? m_addr : 32'h0));
         chk("data_in", 256'(data_in), 256'((m_phase == P_WR) ? m_wdata : 16'h0));
         chk("data_in_vec", flat(data_in_vec), (m_phase == P_WR) ? flat(m_wvec) : 256'h0);
         chk("ack_o", 256'(ack_o), 256'((m_phase == P_ACK) ? (2'b01 << m_own) : 2'b00));
         chk("err_o", 256'(err_o), 256'((m_phase == P_ACK && m_err) ? (2'b01 << m_own) : 2'b00));
         chk("rdata_o", 256'(rdata_o), 256'(m_rdata));
         chk("rvec_o", flat(rvec_o), flat(m_rvec));
         if (ack_o != '0) begin
            $display("txn t=%0t ack=%b err=%b rdata=%h rvec0=%h", $time, ack_o, err_o, rdata_o, rvec_o[0]);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int n;
      for (int r = 0; r < NREQ; r++) for (int l = 0; l < LANES; l++) wvec_i[r][l] = '0;
      for (int l = 0; l < LANES; l++) data_out_vec[l] = '0;
      @(posedge clk); #1 chk_en = 1'b1;
      tick();
      chk("rst_ack", 256'(ack_o), 256'(0));
      chk("rst_address", 256'(address), 256'(0));
      chk("rst_strobes", 256'({memWriteM, memtoRegW, memSrcM}), 256'(0));
      reset = 1'b1;
      tick();

      // 1: scalar write, done during the third strobe cycle
      req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'd5; wdata_i[0] = 16'h2222;
      tick();
      chk("t1_strobe1", 256'(memWriteM), 256'(1));
      chk("t1_addr", 256'(address), 256'(5));
      chk("t1_wdata", 256'(data_in), 256'(16'h2222));
      tick(); chk("t1_strobe2", 256'(memWriteM), 256'(1));
      tick(); chk("t1_strobe3", 256'(memWriteM), 256'(1));
      write_done = 1'b1;
      tick(); write_done = 1'b0;
      chk("t1_ack", 256'(ack_o), 256'(2'b01));
      chk("t1_err", 256'(err_o), 256'(0));
      chk("t1_strobe_off", 256'(memWriteM), 256'(0));
      req_i[0] = 1'b0; we_i[0] = 1'b0;
      tick(); chk("t1_pulse", 256'(ack_o), 256'(0));

      // 2: vector read from requester 1
      req_i[1] = 1'b1; we_i[1] = 1'b0; vec_i[1] = 1'b1; addr_i[1] = 32'd0;
      tick();
      chk("t2_read", 256'(memtoRegW), 256'(1));
      chk("t2_vec", 256'(memSrcM), 256'(1));
      data_ready = 1'b1; data_out = 16'h0007;
      for (int l = 0; l < LANES; l++) data_out_vec[l] = 16'h0004;
      tick(); data_ready = 1'b0;
      chk("t2_ack", 256'(ack_o), 256'(2'b10));
      chk("t2_rvec1", 256'(rvec_o[1]), 256'(16'h0004));
      chk("t2_rdata", 256'(rdata_o), 256'(16'h0007));
      req_i[1] = 1'b0; vec_i[1] = 1'b0;
      tick(); chk("t2_pulse", 256'(ack_o), 256'(0));

      // 3: both requesters held for four writes -> 0,1,0,1
      addr_i[0] = 32'h100; addr_i[1] = 32'h200; wdata_i[0] = 16'h1111; wdata_i[1] = 16'h3333;
      for (int l = 0; l < LANES; l++) begin
         wvec_i[0][l] = 16'(l);
         wvec_i[1][l] = 16'(l + 'h40);
      end
      we_i = 2'b11; vec_i = 2'b10; req_i = 2'b11;
      for (int t = 0; t < 4; t++) begin
         n = 0;
         while (!memWriteM && n < 10) begin tick(); n++; end
         chk("t3_strobe_seen", 256'(memWriteM), 256'(1));
         chk("t3_addr", 256'(address), 256'((t % 2 == 0) ? 32'h100 : 32'h200));
         write_done = 1'b1;
         tick(); write_done = 1'b0;
         chk("t3_grant", 256'(ack_o), 256'((t % 2 == 0) ? 2'b01 : 2'b10));
      end
      req_i = '0; we_i = '0; vec_i = '0;
      tick();

      // 4: read never completes; watchdog aborts after TIMEOUT strobe cycles
      data_out = 16'h0BAD;
      for (int l = 0; l < LANES; l++) data_out_vec[l] = 16'h0BAD;
      req_i[0] = 1'b1; addr_i[0] = 32'd9;
      tick(); n = 1;
      chk("t4_read", 256'(memtoRegW), 256'(1));
      while (ack_o == '0 && n < 30) begin tick(); n++; end
      chk("t4_latency", 256'(n), 256'(9));
      chk("t4_ack", 256'(ack_o), 256'(2'b01));
      chk("t4_err", 256'(err_o), 256'(2'b01));
      chk("t4_rdata_kept", 256'(rdata_o), 256'(16'h0007));
      chk("t4_rvec_kept", 256'(rvec_o[3]), 256'(16'h0004));
      req_i[0] = 1'b0;
      tick();

      // 5: reset during WRITE, then a fresh grant
      req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'd3; wdata_i[0] = 16'h5555;
      tick(2);
      chk("t5_in_write", 256'(memWriteM), 256'(1));
      #2 reset = 1'b0;
      #1;
      chk("t5_rst_strobe", 256'(memWriteM), 256'(0));
      chk("t5_rst_addr", 256'(address), 256'(0));
      chk("t5_rst_rdata", 256'(rdata_o), 256'(0));
      @(posedge clk); #1;
      chk("t5_no_ack", 256'(ack_o), 256'(0));
      #2 reset = 1'b1;
      tick();
      chk("t5_regrant", 256'(memWriteM), 256'(1));
      chk("t5_addr", 256'(address), 256'(3));
      write_done = 1'b1;
      tick(); write_done = 1'b0;
      chk("t5_ack", 256'(ack_o), 256'(2'b01));
      req_i[0] = 1'b0;
      tick();

      // 6: spurious LSU handshakes in IDLE, then a request dropped mid-WRITE
      data_ready = 1'b1; write_done = 1'b1; data_out = 16'hBEEF;
      tick(2);
      chk("t6_idle_strobes", 256'({memWriteM, memtoRegW}), 256'(0));
      chk("t6_idle_ack", 256'(ack_o), 256'(0));
      chk("t6_idle_rdata", 256'(rdata_o), 256'(0));
      data_ready = 1'b0; write_done = 1'b0;
      req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 32'h44; wdata_i[0] = 16'h6666;
      tick();
      req_i[0] = 1'b0; addr_i[0] = 32'h55; wdata_i[0] = 16'h7777; data_ready = 1'b1;
      tick(); data_ready = 1'b0;
      chk("t6_still_write", 256'(memWriteM), 256'(1));
      chk("t6_held_addr", 256'(address), 256'(32'h44));
      chk("t6_held_wdata", 256'(data_in), 256'(16'h6666));
      write_done = 1'b1;
      tick(); write_done = 1'b0;
      chk("t6_ack", 256'(ack_o), 256'(2'b01));
      chk("t6_err", 256'(err_o), 256'(0));
      tick();
      chk("t6_pulse", 256'(ack_o), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
